multistage_priority_demux: RTL and testbench

//  Inverse of the attribute priority mux. Takes one attribute word plus a group select and

---
 rtl/multistage_priority_demux_pkg.sv | 13 +
 rtl/multistage_priority_demux_lane_fifo.sv | 54 +++++
 rtl/multistage_priority_demux.sv | 99 +++++++++
 tb/tb_multistage_priority_demux.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/multistage_priority_demux_pkg.sv
// multistage_priority_demux_pkg: shared widths, stat width and lane slice helper for the priority demux.
package multistage_priority_demux_pkg;
   localparam int STAT_WIDTH = 32;
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction
   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction
endpackage

// File: rtl/multistage_priority_demux_lane_fifo.sv
// attr_lane_fifo: per-lane attribute FIFO; head word is read straight from storage, zero when empty.
module attr_lane_fifo
   import multistage_priority_demux_pkg::*;
#(
   parameter int WIDTH = 135,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);
   localparam int PW = ptr_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_en, pop_en;

   assign full    = count_q == CW'(DEPTH);
   assign empty   = count_q == '0;
   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d = mem_q;
      if (push_en) mem_d[wr_ptr_q] = din;
      wr_ptr_d = wr_ptr_q + PW'(push_en);
      rd_ptr_d = rd_ptr_q + PW'(pop_en);
      count_d  = count_q + CW'(push_en) - CW'(pop_en);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: empty lanes mask the head word to zero.
   always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/multistage_priority_demux.sv
// multistage_priority_demux: steers attribute words to per-lane FIFOs by group select; drops out-of-range selects.
// Optional per-lane/drop statistics counters under MULTISTAGE_PRIORITY_DEMUX_STATS_EN.
module multistage_priority_demux
   import multistage_priority_demux_pkg::*;
#(
   parameter int ATTRIBUTE_DATA_WIDTH = 135,
   parameter int DATA_GROUPS          = 4,
   parameter int GROUP_SEL_WIDTH      = 2,
   parameter int FIFO_DEPTH           = 4
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        valid_i,
   input  logic [ATTRIBUTE_DATA_WIDTH-1:0]             data_i,
   input  logic [GROUP_SEL_WIDTH-1:0]                  group_sel_i,
   output logic                                        ready_o,
   output logic [DATA_GROUPS-1:0]                      valid_groups_o,
   output logic [DATA_GROUPS*ATTRIBUTE_DATA_WIDTH-1:0] data_groups_o,
   input  logic [DATA_GROUPS-1:0]                      ready_groups_i,
   output logic                                        drop_o
`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
   ,
   output logic [DATA_GROUPS*STAT_WIDTH-1:0]           stat_accept_o,
   output logic [STAT_WIDTH-1:0]                       stat_drop_o,
   input  logic                                        stat_clear_i
`endif
);
   localparam int SEL_SPAN = 2 ** GROUP_SEL_WIDTH;

   logic [DATA_GROUPS-1:0] full, empty, push, pop;
   logic [SEL_SPAN-1:0]    full_ext;
   logic                   in_range, accept;
   logic                   drop_q, drop_d;

   assign in_range = 32'(group_sel_i) < 32'(DATA_GROUPS);
   assign accept   = valid_i & ready_o;
   assign drop_o   = drop_q;

   // Padding to the full select span keeps the lookup in bounds for unused codes.
   always_comb begin
      full_ext                  = '0;
      full_ext[DATA_GROUPS-1:0] = full;
      ready_o                   = in_range ? ~full_ext[group_sel_i] : 1'b1;
      drop_d                    = accept & ~in_range;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) drop_q <= 1'b0;
      else       drop_q <= drop_d;
   end

   for (genvar g = 0; g < DATA_GROUPS; g++) begin : g_lane
      assign push[g]           = accept & in_range & (group_sel_i == GROUP_SEL_WIDTH'(g));
      assign pop[g]            = ~empty[g] & ready_groups_i[g];
      assign valid_groups_o[g] = ~empty[g];
      attr_lane_fifo #(
         .WIDTH(ATTRIBUTE_DATA_WIDTH),
         .DEPTH(FIFO_DEPTH)
      ) u_fifo (
         .clk  (clk),
         .reset(reset),
         .push (push[g]),
         .din  (data_i),
         .full (full[g]),
         .pop  (pop[g]),
         .dout (data_groups_o[lane_lo(g, ATTRIBUTE_DATA_WIDTH) +: ATTRIBUTE_DATA_WIDTH]),
         .empty(empty[g])
      );
   end

`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
   logic [STAT_WIDTH-1:0] acc_cnt_q [DATA_GROUPS];
   logic [STAT_WIDTH-1:0] acc_cnt_d [DATA_GROUPS];
   logic [STAT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   // Clear wins over increment; counters stick at all-ones.
   always_comb begin
      for (int i = 0; i < DATA_GROUPS; i++) begin
         acc_cnt_d[i] = stat_clear_i ? '0 :
                        (push[i] && acc_cnt_q[i] != '1) ? acc_cnt_q[i] + 1'b1 : acc_cnt_q[i];
         stat_accept_o[lane_lo(i, STAT_WIDTH) +: STAT_WIDTH] = acc_cnt_q[i];
      end
      drop_cnt_d = stat_clear_i ? '0 :
                   (drop_d && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
   end

   assign stat_drop_o = drop_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DATA_GROUPS; i++) acc_cnt_q[i] <= '0;
         drop_cnt_q <= '0;
      end else begin
         acc_cnt_q  <= acc_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
`endif
endmodule

// File: tb/tb_multistage_priority_demux.sv
// tb_multistage_priority_demux: directed + random stimulus against a per-lane queue model of the demux.
module tb_multistage_priority_demux;
   import multistage_priority_demux_pkg::*;
   localparam int W  = 135;
   localparam int G  = 3;
   localparam int SW = 2;
   localparam int D  = 4;

   logic               clk = 1'b0, reset = 1'b1;
   logic               valid_i = 1'b0;
   logic [W-1:0]       data_i = '0;
   logic [SW-1:0]      group_sel_i = '0;
   logic               ready_o;
   logic [G-1:0]       valid_groups_o;
   logic [G*W-1:0]     data_groups_o;
   logic [G-1:0]       ready_groups_i = '0;
   logic               drop_o;
`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
   logic [G*32-1:0]    stat_accept_o;
   logic [31:0]        stat_drop_o;
   logic               stat_clear_i = 1'b0;
`endif

   int errors = 0, checks = 0;

   multistage_priority_demux #(
      .ATTRIBUTE_DATA_WIDTH(W), .DATA_GROUPS(G), .GROUP_SEL_WIDTH(SW), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .group_sel_i(group_sel_i),
      .ready_o(ready_o), .valid_groups_o(valid_groups_o), .data_groups_o(data_groups_o),
      .ready_groups_i(ready_groups_i), .drop_o(drop_o)
`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
      , .stat_accept_o(stat_accept_o), .stat_drop_o(stat_drop_o), .stat_clear_i(stat_clear_i)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: one queue per lane, accept/drop decided from queue occupancy.
   logic [W-1:0] mq [G][$];
   logic         m_drop = 1'b0;
   logic [31:0]  m_acc [G];
   logic [31:0]  m_dropcnt;

   function automatic logic m_ready();
      return (int'(group_sel_i) < G) ? (mq[group_sel_i].size() < D) : 1'b1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int g = 0; g < G; g++) begin mq[g].delete(); m_acc[g] = 0; end
         m_drop = 1'b0;
         m_dropcnt = 0;
      end else begin
         bit acc, inr;
         acc = valid_i && m_ready();
         inr = int'(group_sel_i) < G;
         for (int g = 0; g < G; g++) begin
            if (mq[g].size() > 0 && ready_groups_i[g]) void'(mq[g].pop_front());
`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
            if (stat_clear_i) m_acc[g] = 0;
            else if (acc && inr && int'(group_sel_i) == g && m_acc[g] != 32'hFFFF_FFFF) m_acc[g]++;
`endif
         end
`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
         if (stat_clear_i) m_dropcnt = 0;
         else if (acc && !inr && m_dropcnt != 32'hFFFF_FFFF) m_dropcnt++;
`endif
         if (acc && inr) mq[group_sel_i].push_back(data_i);
         m_drop = acc && !inr;
      end
   end

   always @(negedge clk) begin
      chk("ready_o", 256'(ready_o), 256'(m_ready()));
      chk("drop_o", 256'(drop_o), 256'(m_drop));
      for (int g = 0; g < G; g++) begin
         chk($sformatf("lane%0d_valid", g), 256'(valid_groups_o[g]), 256'(mq[g].size() > 0));
         chk($sformatf("lane%0d_data", g), 256'(data_groups_o[g*W +: W]),
             256'(mq[g].size() > 0 ? mq[g][0] : '0));
`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
         chk($sformatf("lane%0d_stat", g), 256'(stat_accept_o[g*32 +: 32]), 256'(m_acc[g]));
`endif
      end
`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
      chk("stat_drop", 256'(stat_drop_o), 256'(m_dropcnt));
`endif
   end

   function automatic logic [W-1:0] rnd_word();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[W-1:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_word(input logic [SW-1:0] sel, input logic [W-1:0] d);
      bit done = 0;
      valid_i = 1'b1; group_sel_i = sel; data_i = d;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = ready_o;
         step();
      end
      if (!done) chk("push_timeout", 256'(0), 256'(1));
      valid_i = 1'b0;
   endtask

   logic [W-1:0] w [5];
   logic [W-1:0] got [$];
   logic [W-1:0] a;
   int k;

   initial begin
      #22 reset = 1'b0;
      step();
      // 1: single word to lane 2
      a = rnd_word();
      valid_i = 1'b1; group_sel_i = 2'd2; data_i = a;
      @(negedge clk);
      chk("t1_ready", 256'(ready_o), 256'(1));
      step();
      valid_i = 1'b0;
      @(negedge clk);
      chk("t1_valid", 256'(valid_groups_o), 256'(3'b100));
      chk("t1_data", 256'(data_groups_o[2*W +: W]), 256'(a));
      chk("t1_lane0_zero", 256'(data_groups_o[0 +: W]), 256'(0));
      ready_groups_i = 3'b100;
      step();
      ready_groups_i = '0;
      // 2: five words to lane 0 while blocked, then release
      for (int i = 0; i < 5; i++) w[i] = rnd_word();
      k = 0;
      got.delete();
      for (int c = 0; c < 30; c++) begin
         valid_i = k < 5;
         data_i = w[k < 5 ? k : 4];
         group_sel_i = 2'd0;
         if (c == 8) ready_groups_i[0] = 1'b1;
         @(negedge clk);
         if (c == 4 || c == 6) chk("t2_ready_full", 256'(ready_o), 256'(0));
         if (valid_i && ready_o) k++;
         if (valid_groups_o[0] && ready_groups_i[0]) got.push_back(data_groups_o[0 +: W]);
         step();
      end
      valid_i = 1'b0;
      ready_groups_i = '0;
      chk("t2_count", 256'(got.size()), 256'(5));
      for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("t2_word%0d", i), 256'(got[i]), 256'(w[i]));
      // 3: full lane 1, simultaneous pop does not free the slot
      for (int i = 0; i < 4; i++) push_word(2'd1, rnd_word());
      a = rnd_word();
      valid_i = 1'b1; group_sel_i = 2'd1; data_i = a; ready_groups_i[1] = 1'b1;
      @(negedge clk);
      chk("t3_ready_full", 256'(ready_o), 256'(0));
      step();
      ready_groups_i = '0;
      @(negedge clk);
      chk("t3_ready_after_pop", 256'(ready_o), 256'(1));
      step();
      valid_i = 1'b0;
      ready_groups_i = 3'b111;
      repeat (6) step();
      ready_groups_i = '0;
      // 4: out-of-range select is dropped
      valid_i = 1'b1; group_sel_i = 2'd3; data_i = rnd_word();
      @(negedge clk);
      chk("t4_ready", 256'(ready_o), 256'(1));
      step();
      valid_i = 1'b0;
      @(negedge clk);
      chk("t4_drop", 256'(drop_o), 256'(1));
      chk("t4_no_valid", 256'(valid_groups_o), 256'(0));
`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
      chk("t4_stat_drop", 256'(stat_drop_o), 256'(1));
`endif
      step();
      @(negedge clk);
      chk("t4_drop_gone", 256'(drop_o), 256'(0));
      step();
      // 5: random traffic with an asynchronous reset in the middle
      for (int c = 0; c < 600; c++) begin
         valid_i = $urandom_range(0, 3) != 0;
         group_sel_i = SW'($urandom_range(0, 3));
         data_i = rnd_word();
         ready_groups_i = G'($urandom);
         if (c == 300) begin
            #1 reset = 1'b1;
            #1;
            chk("t5_reset_valid", 256'(valid_groups_o), 256'(0));
            chk("t5_reset_ready", 256'(ready_o), 256'(1));
            step();
            #1 reset = 1'b0;
         end
         step();
      end
      valid_i = 1'b0;
      ready_groups_i = 3'b111;
      repeat (6) step();
`ifdef MULTISTAGE_PRIORITY_DEMUX_STATS_EN
      // 6: clear coincident with the 3rd accept on lane 0
      push_word(2'd0, rnd_word());
      push_word(2'd0, rnd_word());
      stat_clear_i = 1'b1;
      push_word(2'd0, rnd_word());
      stat_clear_i = 1'b0;
      @(negedge clk);
      chk("t6_cleared", 256'(stat_accept_o[31:0]), 256'(0));
      step();
      push_word(2'd0, rnd_word());
      @(negedge clk);
      chk("t6_after_clear", 256'(stat_accept_o[31:0]), 256'(1));
      step();
`endif
      repeat (4) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
